// File: rtl/stage_sequencer_pkg.sv
// Shared types for the multicycle stage sequencer.
// Optional perf counters are enabled with SEQ_PERF_COUNTERS_EN.
package stage_sequencer_pkg;
    localparam int NSTAGE = 5;
    localparam int CNT_W  = 64;

    localparam int STG_FETCH  = 0;
    localparam int STG_DECODE = 1;
    localparam int STG_EXEC   = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WRITE  = 4;

    typedef logic [NSTAGE-1:0] stage_vec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WRITE,
        S_HALT
    } seq_state_t;
endpackage

// File: rtl/stage_sequencer_if.sv
// Enable/fin handshake bundle between the sequencer and the stages.
// Decode also reports skip_mem and halt alongside its fin.
interface stage_sequencer_if;
    import stage_sequencer_pkg::*;

    stage_vec_t stage_en;
    stage_vec_t stage_fin;
    logic       skip_mem;
    logic       halt;

    modport master (
        output stage_en,
        input  stage_fin,
        input  skip_mem,
        input  halt
    );

    modport slave (
        input  stage_en,
        output stage_fin,
        output skip_mem,
        output halt
    );
endinterface

// File: rtl/stage_sequencer_counters.sv
// Saturating busy-cycle and retired-instruction counters.
// Instantiated only when SEQ_PERF_COUNTERS_EN is defined.
module seq_perf_counters
    import stage_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_inc,
    input  logic             ret_inc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (cyc_inc && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (ret_inc && (instret_cnt != '1))
                instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/stage_sequencer.sv
// Multicycle control FSM: steps one instruction through the five stages.
// Define SEQ_PERF_COUNTERS_EN to add the cycle_cnt/instret_cnt ports.
module stage_sequencer
    import stage_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop_req,
    input  logic stall,
    stage_sequencer_if.master sif,
    output logic busy,
    output logic halted,
    output logic inst_done
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);
    seq_state_t state_q, state_d;
    logic       skip_q, skip_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        sif.stage_en = '0;
        inst_done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stall)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                sif.stage_en[STG_FETCH] = 1'b1;
                if (sif.stage_fin[STG_FETCH])
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                sif.stage_en[STG_DECODE] = 1'b1;
                if (sif.stage_fin[STG_DECODE]) begin
                    skip_d = sif.skip_mem;
                    if (sif.halt)
                        state_d = S_HALT;
                    else if (sif.skip_mem)
                        state_d = S_WRITE;
                    else
                        state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                sif.stage_en[STG_EXEC] = 1'b1;
                if (sif.stage_fin[STG_EXEC])
                    state_d = skip_q ? S_WRITE : S_MEM;
            end
            S_MEM: begin
                sif.stage_en[STG_MEM] = 1'b1;
                if (sif.stage_fin[STG_MEM])
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                sif.stage_en[STG_WRITE] = 1'b1;
                if (sif.stage_fin[STG_WRITE]) begin
                    inst_done = 1'b1;
                    // stop and stall both park in IDLE; start resumes either
                    if (stop_req || stall)
                        state_d = S_IDLE;
                    else
                        state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted = (state_q == S_HALT);

`ifdef SEQ_PERF_COUNTERS_EN
    seq_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .cyc_inc     (busy),
        .ret_inc     (inst_done),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed table-driven bench for stage_sequencer.
// Counter checks are active when SEQ_PERF_COUNTERS_EN is defined.
module tb_stage_sequencer;
    import stage_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic stop_req;
    logic stall;
    logic busy;
    logic halted;
    logic inst_done;

    stage_sequencer_if sif ();

`ifdef SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
`endif

    int nvec = 0;
    int nerr = 0;
    longint exp_cyc = 0;
    longint exp_ret = 0;

    always #5 clk = ~clk;

    stage_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop_req    (stop_req),
        .stall       (stall),
        .sif         (sif),
        .busy        (busy),
        .halted      (halted),
        .inst_done   (inst_done)
`ifdef SEQ_PERF_COUNTERS_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       stall;
        logic       skip;
        logic       halt;
        logic [4:0] fin;
        logic [4:0] en;
        logic       busy;
        logic       halted;
        logic       done;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        logic r, logic s, logic sp, logic sl, logic sk, logic h,
        logic [4:0] f, logic [4:0] e, logic b, logic hd, logic d,
        string n);
        vec_t x;
        x.rst = r; x.start = s; x.stop = sp; x.stall = sl;
        x.skip = sk; x.halt = h; x.fin = f; x.en = e;
        x.busy = b; x.halted = hd; x.done = d; x.name = n;
        return x;
    endfunction

    task automatic step(input vec_t x);
        logic [7:0] act, req;
        @(negedge clk);
        rst          = x.rst;
        start        = x.start;
        stop_req     = x.stop;
        stall        = x.stall;
        sif.skip_mem = x.skip;
        sif.halt     = x.halt;
        sif.stage_fin = x.fin;
        #1;
        nvec++;
        act = {sif.stage_en, busy, halted, inst_done};
        req = {x.en, x.busy, x.halted, x.done};
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: {en,busy,halted,done} got %b required %b",
                     x.name, act, req);
        end
`ifdef SEQ_PERF_COUNTERS_EN
        if (cycle_cnt !== CNT_W'(exp_cyc) || instret_cnt !== CNT_W'(exp_ret)) begin
            nerr++;
            $display("FAIL %s cnt: cyc/ret got %0d/%0d required %0d/%0d",
                     x.name, cycle_cnt, instret_cnt, exp_cyc, exp_ret);
        end
`endif
        if (x.rst) begin
            exp_cyc = 0;
            exp_ret = 0;
        end else begin
            if (x.busy) exp_cyc++;
            if (x.done) exp_ret++;
        end
    endtask

    localparam logic [4:0] F = 5'b11111;
    localparam logic [4:0] Z = 5'b00000;
    localparam logic [4:0] EF = 5'b00001;
    localparam logic [4:0] ED = 5'b00010;
    localparam logic [4:0] EE = 5'b00100;
    localparam logic [4:0] EM = 5'b01000;
    localparam logic [4:0] EW = 5'b10000;

    initial begin
        rst = 1'b1; start = 1'b0; stop_req = 1'b0; stall = 1'b0;
        sif.skip_mem = 1'b0; sif.halt = 1'b0; sif.stage_fin = '0;
        repeat (2) @(posedge clk);

        tbl.push_back(v(0,0,0,0,0,0,Z, Z,0,0,0, "reset_state"));
        tbl.push_back(v(0,1,0,1,0,0,F, Z,0,0,0, "idle_stall_blocks"));
        tbl.push_back(v(0,1,0,0,0,0,F, Z,0,0,0, "idle_start"));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(v(0,0,0,0,0,0,F, EF,1,0,0, "t1_fetch"));
            tbl.push_back(v(0,0,0,0,0,0,F, ED,1,0,0, "t1_decode"));
            tbl.push_back(v(0,0,0,0,0,0,F, EE,1,0,0, "t1_exec"));
            tbl.push_back(v(0,0,0,0,0,0,F, EM,1,0,0, "t1_mem"));
            tbl.push_back(v(0,0,0,0,0,0,F, EW,1,0,1, "t1_write"));
        end
        tbl.push_back(v(0,0,0,0,0,0,F, EF,1,0,0, "t2_fetch"));
        tbl.push_back(v(0,0,0,0,1,0,F, ED,1,0,0, "t2_decode_skip"));
        tbl.push_back(v(0,0,0,0,0,0,F, EW,1,0,1, "t2_write"));
        tbl.push_back(v(0,0,0,0,0,0,F, EF,1,0,0, "t2_next_fetch"));
        tbl.push_back(v(0,0,0,0,0,0,5'b11101, ED,1,0,0, "other_fin_ignored"));
        tbl.push_back(v(0,0,0,0,0,0,ED, ED,1,0,0, "decode_fin"));
        tbl.push_back(v(0,0,0,0,0,0,F, EE,1,0,0, "t5_exec"));
        tbl.push_back(v(0,0,1,0,0,0,Z, EM,1,0,0, "t5_mem_wait"));
        tbl.push_back(v(0,0,1,0,0,0,F, EM,1,0,0, "t5_mem_fin"));
        tbl.push_back(v(0,0,1,0,0,0,F, EW,1,0,1, "t5_write_stop"));
        tbl.push_back(v(0,0,0,0,0,0,F, Z,0,0,0, "t5_idle"));
        tbl.push_back(v(0,1,0,0,0,0,F, Z,0,0,0, "restart"));
        tbl.push_back(v(0,0,0,0,0,0,F, EF,1,0,0, "st_fetch"));
        tbl.push_back(v(0,0,0,0,0,0,F, ED,1,0,0, "st_decode"));
        tbl.push_back(v(0,0,0,0,0,0,F, EE,1,0,0, "st_exec"));
        tbl.push_back(v(0,0,0,0,0,0,F, EM,1,0,0, "st_mem"));
        tbl.push_back(v(0,0,0,1,0,0,F, EW,1,0,1, "st_write_stall"));
        tbl.push_back(v(0,1,0,1,0,0,F, Z,0,0,0, "st_idle_held"));
        tbl.push_back(v(0,1,0,0,0,0,F, Z,0,0,0, "st_release"));
        tbl.push_back(v(0,0,0,0,0,0,F, EF,1,0,0, "t3_fetch"));
        tbl.push_back(v(0,0,0,0,0,0,F, ED,1,0,0, "t3_decode"));

        foreach (tbl[i]) step(tbl[i]);

`ifdef SEQ_PERF_COUNTERS_EN
        nvec++;
        if (exp_ret < 4) begin
            nerr++;
            $display("FAIL instret_min: model %0d required at least 4", exp_ret);
        end
`endif

        // EXEC held for 7 cycles without fin, finishing on the 8th
        for (int i = 0; i < 8; i++)
            step(v(0,0,0,0,0,0, (i < 7) ? Z : F, EE,1,0,0, "t3_exec_hold"));
        step(v(0,0,0,0,0,0,F, EM,1,0,0, "t3_mem"));
        step(v(0,0,0,0,0,0,F, EW,1,0,1, "t3_write"));

        // halt at decode, with skip_mem also set
        step(v(0,0,0,0,0,0,F, EF,1,0,0, "t4_fetch"));
        step(v(0,0,0,0,1,1,F, ED,1,0,0, "t4_decode_halt"));
        for (int i = 0; i < 10; i++)
            step(v(0,1,0,0,0,0,F, Z,0,1,0, "t4_halted"));
        step(v(1,1,0,0,0,0,F, Z,0,1,0, "t4_rst_edge"));
        step(v(0,0,0,0,0,0,F, Z,0,0,0, "t4_cleared"));

        // reset in the middle of a stalled EXEC
        step(v(0,1,0,0,0,0,F, Z,0,0,0, "t6_start"));
        step(v(0,0,0,0,0,0,F, EF,1,0,0, "t6_fetch"));
        step(v(0,0,0,0,0,0,F, ED,1,0,0, "t6_decode"));
        step(v(0,0,0,0,0,0,Z, EE,1,0,0, "t6_exec"));
        step(v(1,0,0,0,0,0,Z, EE,1,0,0, "t6_rst_in_exec"));
        step(v(0,1,0,0,0,0,F, Z,0,0,0, "t6_after_rst"));
        step(v(0,0,0,0,0,0,F, EF,1,0,0, "t6_refetch"));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
